// File: rtl/pll_reset_seq.sv
// ============================================================================
// pll_reset_seq : debounces PLL lock, sequences the system reset and counts
//                 lock losses. Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module pll_reset_seq #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       locked,
  input  logic       sw_reset_req,
  output logic       sys_resetn,
  output logic [1:0] state,
  output logic [7:0] lock_loss_cnt
);

  localparam int MAX_CYCLES = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] C_STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_locked_s;
  logic [CNT_W-1:0]       r_cnt;
  state_t                 r_state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], locked};
    end
  end

  assign w_locked_s = r_sync[SYNC_STAGES-1];
  assign state      = r_state;

  // sys_resetn is loaded in every branch that lands in RUN, so it tracks state
  // on the same edge with no decode glitch on the output.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= WAIT_LOCK;
      r_cnt         <= '0;
      sys_resetn    <= 1'b0;
      lock_loss_cnt <= 8'd0;
    end else begin
      sys_resetn <= 1'b0;
      case (r_state)
        WAIT_LOCK: begin
          if (!w_locked_s) begin
            r_cnt <= '0;
          end else if (r_cnt == C_STABLE_LAST) begin
            r_state <= HOLD;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + C_CNT_ONE;
          end
        end
        HOLD: begin
          if (!w_locked_s) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
            if (lock_loss_cnt != 8'hFF) lock_loss_cnt <= lock_loss_cnt + 8'd1;
          end else if (sw_reset_req) begin
            r_cnt <= '0;
          end else if (r_cnt == C_HOLD_LAST) begin
            r_state    <= RUN;
            r_cnt      <= '0;
            sys_resetn <= 1'b1;
          end else begin
            r_cnt <= r_cnt + C_CNT_ONE;
          end
        end
        RUN: begin
          if (!w_locked_s) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
            if (lock_loss_cnt != 8'hFF) lock_loss_cnt <= lock_loss_cnt + 8'd1;
          end else if (sw_reset_req) begin
            r_state <= HOLD;
            r_cnt   <= '0;
          end else begin
            sys_resetn <= 1'b1;
          end
        end
        default: begin
          r_state <= WAIT_LOCK;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pll_reset_seq.sv
// ============================================================================
// tb_pll_reset_seq : table-driven and randomised checks of pll_reset_seq.
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pll_reset_seq;

  localparam int SYNC   = 2;
  localparam int STABLE = 8;
  localparam int HOLDC  = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       locked = 1'b0;
  logic       sw_reset_req = 1'b0;
  logic       sys_resetn;
  logic [1:0] state;
  logic [7:0] lock_loss_cnt;

  pll_reset_seq #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE),
    .HOLD_CYCLES  (HOLDC)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .locked       (locked),
    .sw_reset_req (sw_reset_req),
    .sys_resetn   (sys_resetn),
    .state        (state),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: timestamps of when the stability window and the hold
  // window began, evaluated against the edge index.
  int m_phase;
  int m_win_start;
  int m_hold_start;
  int m_loss;
  int m_cyc;
  bit m_q[$];

  typedef struct {
    bit         lk;
    bit         sw;
    int         n;
    logic [1:0] st;
    bit         rn;
    logic [7:0] loss;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_phase      = 0;
    m_win_start  = -1;
    m_hold_start = 0;
    m_loss       = 0;
    m_cyc        = 0;
    m_q.delete();
    for (int i = 0; i < SYNC; i++) m_q.push_back(1'b0);
  endfunction

  function automatic void model_step(input bit lk, input bit sw);
    bit ls;
    int e;
    ls = m_q[0];
    void'(m_q.pop_front());
    m_q.push_back(lk);
    e = m_cyc;
    m_cyc++;
    if (m_phase == 0) begin
      if (!ls) m_win_start = -1;
      else begin
        if (m_win_start < 0) m_win_start = e;
        if (e - m_win_start + 1 >= STABLE) begin
          m_phase      = 1;
          m_hold_start = e + 1;
        end
      end
    end else begin
      if (!ls) begin
        m_phase     = 0;
        m_win_start = -1;
        if (m_loss < 255) m_loss++;
      end else if (sw) begin
        m_phase      = 1;
        m_hold_start = e + 1;
      end else if (m_phase == 1 && (e - m_hold_start + 1 >= HOLDC)) begin
        m_phase = 2;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(locked, sw_reset_req);
    #1;
    check("model_state", state, m_phase);
    check("model_sys_resetn", sys_resetn, (m_phase == 2));
    check("model_loss", lock_loss_cnt, m_loss);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    resetn       = 1'b0;
    locked       = 1'b0;
    sw_reset_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("reset_state", state, 2'd0);
    check("reset_sys_resetn", sys_resetn, 1'b0);
    check("reset_loss", lock_loss_cnt, 8'd0);
    resetn = 1'b1;
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 10, 2'd1, 1'b0, 8'd0};
    tbl[1] = '{1'b1, 1'b0,  3, 2'd1, 1'b0, 8'd0};
    tbl[2] = '{1'b1, 1'b0,  1, 2'd2, 1'b1, 8'd0};
    tbl[3] = '{1'b1, 1'b1,  1, 2'd1, 1'b0, 8'd0};
    tbl[4] = '{1'b1, 1'b0,  3, 2'd1, 1'b0, 8'd0};
    tbl[5] = '{1'b1, 1'b0,  1, 2'd2, 1'b1, 8'd0};
    tbl[6] = '{1'b0, 1'b0,  2, 2'd2, 1'b1, 8'd0};
    tbl[7] = '{1'b0, 1'b0,  1, 2'd0, 1'b0, 8'd1};
    tbl[8] = '{1'b1, 1'b0, 12, 2'd1, 1'b0, 8'd1};
    tbl[9] = '{1'b1, 1'b0,  2, 2'd2, 1'b1, 8'd1};

    // Power-up, soft reset from RUN, lock loss and re-release.
    do_reset();
    for (int r = 0; r < 10; r++) begin
      locked       = tbl[r].lk;
      sw_reset_req = tbl[r].sw;
      ticks(tbl[r].n);
      sw_reset_req = 1'b0;
      check($sformatf("tbl%0d_state", r), state, tbl[r].st);
      check($sformatf("tbl%0d_sys_resetn", r), sys_resetn, tbl[r].rn);
      check($sformatf("tbl%0d_loss", r), lock_loss_cnt, tbl[r].loss);
    end

    // Soft reset in RUN, then again mid-HOLD restarts the hold window.
    sw_reset_req = 1'b1; tick(); sw_reset_req = 1'b0;
    check("sw_run_to_hold", state, 2'd1);
    ticks(2);
    sw_reset_req = 1'b1; tick(); sw_reset_req = 1'b0;
    check("sw_hold_restart", state, 2'd1);
    ticks(3);
    check("hold_restart_still_low", sys_resetn, 1'b0);
    tick();
    check("hold_restart_release", sys_resetn, 1'b1);

    // Lock loss and soft request in the same cycle: lock loss wins.
    locked = 1'b0;
    ticks(2);
    check("simul_pre_run", state, 2'd2);
    sw_reset_req = 1'b1; tick(); sw_reset_req = 1'b0;
    check("simul_state", state, 2'd0);
    check("simul_loss", lock_loss_cnt, 8'd2);

    // Soft request during WAIT_LOCK is ignored.
    locked = 1'b1;
    ticks(5);
    sw_reset_req = 1'b1; tick(); sw_reset_req = 1'b0;
    ticks(3);
    check("wait_sw_ignored", state, 2'd0);
    tick();
    check("wait_sw_hold", state, 2'd1);

    // Debounce: a one-cycle drop restarts the stability window.
    do_reset();
    locked = 1'b1; ticks(5);
    locked = 1'b0; ticks(1);
    locked = 1'b1; ticks(9);
    check("debounce_wait", state, 2'd0);
    tick();
    check("debounce_hold", state, 2'd1);
    check("debounce_loss", lock_loss_cnt, 8'd0);

    // Saturation over 300 lock-loss events.
    for (int k = 0; k < 300; k++) begin
      locked = 1'b1; ticks(10);
      locked = 1'b0; ticks(3);
    end
    check("sat_loss", lock_loss_cnt, 8'd255);
    locked = 1'b1; ticks(11);
    check("sat_hold", state, 2'd1);

    // Asynchronous reset mid-HOLD, observed before any clock edge.
    #2;
    resetn = 1'b0;
    #1;
    check("async_state", state, 2'd0);
    check("async_sys_resetn", sys_resetn, 1'b0);
    check("async_loss", lock_loss_cnt, 8'd0);

    // Randomised segments against the reference model.
    do_reset();
    begin
      int done;
      bit val;
      int len;
      done = 0;
      while (done < 3000) begin
        val = ($urandom_range(0, 3) != 0);
        len = val ? $urandom_range(1, 40) : $urandom_range(1, 4);
        locked = val;
        for (int i = 0; i < len; i++) begin
          sw_reset_req = (!sw_reset_req) && ($urandom_range(0, 19) == 0);
          tick();
          done++;
        end
        sw_reset_req = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
